// File: rtl/module_display_scan.sv
// module_display_scan: time-multiplexed 4-digit common-anode 7-segment driver.
// A loaded value waits in a shadow register and moves into the displayed
// (active) register only on the last cycle of digit 3's slot, so a frame never
// shows a mix of old and new digits. Each slot opens with a short all-dark
// interval to suppress ghosting between adjacent digits.
//
// Handshake: load_i is a plain 1-cycle strobe with no back-pressure; value_i
// is captured on every cycle load_i is high, and the most recent capture wins.
module module_display_scan #(
  parameter int TICK_DIV  = 27000,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic        blank_lz_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic [1:0]  digit_idx_o,
  output logic        frame_o
);

  localparam int              CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {S_BLANK = 1'b0, S_ON = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   active_q, active_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          wrap;
  logic          boundary;
  logic [3:0]    nibble;
  logic          lz_dark;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot timing: counter wraps every TICK_DIV cycles and steps the digit index.
  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    boundary = wrap && (idx_q == 2'd3);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
  end

  // Double buffer: new values queue in the shadow and swap in at frame end;
  // a load on the boundary cycle itself goes straight to the active register.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (load_i) begin
      shadow_d  = value_i;
      pending_d = 1'b1;
    end
    if (boundary) begin
      if (load_i) begin
        active_d = value_i;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end
  end

  // Select the current digit's nibble and decide whether it is a leading zero
  // (this digit and every digit above it are zero).
  always_comb begin
    nibble  = active_q[3:0];
    lz_dark = 1'b0;
    case (idx_q)
      2'd3: begin
        nibble  = active_q[15:12];
        lz_dark = (active_q[15:12] == 4'h0);
      end
      2'd2: begin
        nibble  = active_q[11:8];
        lz_dark = (active_q[15:8] == 8'h00);
      end
      2'd1: begin
        nibble  = active_q[7:4];
        lz_dark = (active_q[15:4] == 12'h000);
      end
      default: begin
        nibble  = active_q[3:0];
        lz_dark = 1'b0;
      end
    endcase
  end

  // Scan FSM: next state plus the next registered anode/segment pattern.
  always_comb begin
    state_d = state_q;
    an_d    = 4'b1111;
    seg_d   = 7'h7F;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = S_ON;
      end
      S_ON: begin
        if (wrap) state_d = S_BLANK;
        if (!(blank_lz_i && lz_dark)) begin
          an_d  = ~(4'b0001 << idx_q);
          seg_d = seg_decode(nibble);
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  // State, counters, buffers and output registers; all clear asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_BLANK;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      active_q  <= 16'h0000;
      pending_q <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign digit_idx_o = idx_q;
  assign frame_o     = boundary;

endmodule

// File: tb/tb_module_display_scan.sv
// tb_module_display_scan: randomized and directed stimulus against a
// time-indexed reference model of the display scanner.
module tb_module_display_scan;

  localparam int TICK_DIV  = 8;
  localparam int BLANK_CYC = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_i;
  logic        load_i;
  logic        blank_lz_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic [1:0]  digit_idx_o;
  logic        frame_o;

  always #5 clk = ~clk;

  module_display_scan #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_i     (value_i),
    .load_i      (load_i),
    .blank_lz_i  (blank_lz_i),
    .an_o        (an_o),
    .seg_o       (seg_o),
    .digit_idx_o (digit_idx_o),
    .frame_o     (frame_o)
  );

  // ---------------- reference model ----------------
  // t counts clock edges since reset release; slot position and digit follow
  // from it arithmetically. The shown value changes only at frame boundaries.
  int          n_checks = 0;
  int          n_errors = 0;
  int          t;
  logic [15:0] m_active;
  logic [15:0] m_pend_val;
  logic        m_pend;
  logic [6:0]  seg_tab [16];

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  task automatic model_reset();
    t          = 0;
    m_active   = 16'h0000;
    m_pend_val = 16'h0000;
    m_pend     = 1'b0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs at the negedge, predict, step, check at the
  // following negedge.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic lz);
    int         pos;
    int         dig;
    int         nidx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [3:0] nib;
    load_i     = ld;
    value_i    = v;
    blank_lz_i = lz;
    pos   = t % TICK_DIV;
    dig   = (t / TICK_DIV) % 4;
    e_an  = 4'b1111;
    e_seg = 7'h7F;
    if (pos >= BLANK_CYC && !(lz && dig != 0 && (m_active >> (4 * dig)) == 16'h0000)) begin
      e_an  = ~(4'b0001 << dig);
      nib   = m_active[4*dig +: 4];
      e_seg = seg_tab[nib];
    end
    if (ld) begin
      m_pend_val = v;
      m_pend     = 1'b1;
    end
    if (pos == TICK_DIV - 1 && dig == 3) begin
      if (m_pend) m_active = m_pend_val;
      m_pend = 1'b0;
    end
    t++;
    @(posedge clk);
    @(negedge clk);
    nidx = (t / TICK_DIV) % 4;
    check("an", {12'h0, an_o}, {12'h0, e_an});
    check("seg", {9'h0, seg_o}, {9'h0, e_seg});
    check("idx", {14'h0, digit_idx_o}, 16'(nidx));
    check("frame", {15'h0, frame_o}, {15'h0, ((t % TICK_DIV == TICK_DIV - 1) && nidx == 3)});
    load_i = 1'b0;
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, lz);
  endtask

  // Advance until the cycle about to be stepped is the frame boundary.
  task automatic to_boundary(input logic lz);
    for (int i = 0; i < 4 * TICK_DIV + 2; i++) begin
      if ((t % TICK_DIV == TICK_DIV - 1) && ((t / TICK_DIV) % 4 == 3)) break;
      cycle(1'b0, 16'h0000, lz);
    end
    check("frame_seen", {15'h0, frame_o}, 16'h0001);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    load_i     = 1'b0;
    value_i    = 16'h0000;
    blank_lz_i = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check("rst_an", {12'h0, an_o}, 16'h000F);
    check("rst_seg", {9'h0, seg_o}, 16'h007F);
    check("rst_frame", {15'h0, frame_o}, 16'h0000);
    check("rst_idx", {14'h0, digit_idx_o}, 16'h0000);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        lz_r;
    logic        ld_r;
    logic [15:0] v_r;

    do_reset();
    // Reset release: blank, digit 0 lit, then digit 1 blank, showing 0000.
    idle(40, 1'b0);

    // Load mid-frame: display holds until the boundary.
    idle(3, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0);
    idle(70, 1'b0);

    // Load exactly on the boundary cycle: bypass into the next frame.
    to_boundary(1'b0);
    cycle(1'b1, 16'h00AF, 1'b0);
    idle(36, 1'b0);

    // Leading-zero suppression with 0005 then 0000.
    cycle(1'b1, 16'h0005, 1'b1);
    idle(70, 1'b1);
    cycle(1'b1, 16'h0000, 1'b1);
    idle(70, 1'b1);
    cycle(1'b1, 16'h0300, 1'b1);
    idle(70, 1'b1);

    // Two loads in one frame: last one wins.
    to_boundary(1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 16'h1111, 1'b0);
    idle(3, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    idle(70, 1'b0);

    // Reset during digit 2's lit interval.
    for (int i = 0; i < 4 * TICK_DIV + 2; i++) begin
      if ((t % TICK_DIV == BLANK_CYC + 2) && ((t / TICK_DIV) % 4 == 2)) break;
      cycle(1'b0, 16'h0000, 1'b0);
    end
    check("pre_rst_an", {12'h0, an_o}, 16'h000B);
    rst = 1'b0;
    #1;
    check("async_an", {12'h0, an_o}, 16'h000F);
    check("async_seg", {9'h0, seg_o}, 16'h007F);
    check("async_idx", {14'h0, digit_idx_o}, 16'h0000);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    idle(40, 1'b0);

    // Randomized traffic.
    lz_r = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 49) == 0) lz_r = ~lz_r;
      ld_r = ($urandom_range(0, 11) == 0);
      v_r  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v_r[15:8] = 8'h00;
      cycle(ld_r, v_r, lz_r);
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
